debug_char_writer: RTL and testbench
====================================

// Module: debug_char_writer
// PURPOSE
// AXI-light initiator that emits debug characters as single-beat writes to the
// debug character address. Characters are pushed by local logic (boot ROM
// sequencer, trap handler, test harness) into a small FIFO and drained one
// write at a time. The debug character detector on the bus decodes these writes,
// so this block is the transmitting end of the same debug console path.
// PARAMETERS
// ADDR_DEBUG  32'h0000_0000  AWADDR driven for every character write
// DEPTH       8              FIFO entries; power of two, >= 2
// PORTS
// clk        in   1             clock, all logic rising-edge
// res        in   1             synchronous reset, active-high
// push       in   1             enqueue push_char this cycle
// push_char  in   `ASCII_WIDTH  character to send
// hold       in   1             when high, no NEW write is started
// full       out  1             FIFO full; push ignored while high
// idle       out  1             FIFO empty and FSM in IDLE
// level      out  $clog2(DEPTH)+1  FIFO occupancy
// sent       out  1             1-cycle pulse on each completed write (B handshake)
// overflow   out  1             sticky: a push arrived while full
// m_axi      if_axi_light.master  write channel used; read channel idle
// BEHAVIOUR
// Reset (res=1 at a rising edge): FIFO emptied, level=0, full=0, idle=1, sent=0,
//   overflow=0, AWVALID=WVALID=BREADY=0, ARVALID=RREADY=0, FSM=IDLE. Reset
//   mid-transaction drops VALIDs at that edge; the character in flight is lost.
// Outputs registered; full/idle/level reflect state after the last edge.
// FIFO: push accepted iff push=1 and full=0; push while full -> char dropped,
//   overflow set until reset. Pop happens only on IDLE->SEND. Push and pop in
//   the same cycle: level unchanged. Pointers wrap modulo DEPTH.
// FSM states:
//   IDLE: if level!=0 and hold=0 -> SEND; pop head into data register;
//     AWVALID=WVALID=1 from next cycle. So push into empty FIFO at edge N ->
//     AWVALID/WVALID high after edge N+1.
//   SEND: AWADDR=ADDR_DEBUG, WDATA={zeros,char}, WSTRB=4'b0001. AWVALID drops
//     on the edge where AWREADY=1; WVALID likewise with WREADY, independently.
//     Both handshakes may occur in the same cycle or in either order. When both
//     have completed -> RESP with BREADY=1.
//   RESP: BREADY=1; on BVALID=1 -> IDLE, BREADY=0, sent=1 for one cycle.
//     Response code ignored.
// hold sampled only in IDLE; raising hold in SEND/RESP does not abort.
// AWADDR/WDATA stable while the respective VALID is high (AXI rule).
// Throughput: at best one character per 3 cycles (IDLE, SEND, RESP).
// Read channel: ARVALID=0, RREADY=0 permanently.
// TESTING
// 1) push 'H'(8'h48) at edge N, slave always ready -> AWVALID/WVALID after N+1,
//    WDATA=32'h48, AWADDR=0, WSTRB=1; BVALID next -> sent pulse, idle=1.
// 2) push "OK\n" back-to-back with DEPTH=8 -> three writes in order 4F,4B,0A;
//    level peaks at 2 (first char already popped); idle only after third sent.
// 3) AWREADY 3 cycles before WREADY, then reversed -> each VALID drops on its
//    own handshake; RESP entered only after both; one write per char.
// 4) hold=1, push 9 chars with DEPTH=8 -> full=1 after 8, 9th dropped,
//    overflow=1; release hold -> exactly 8 writes, overflow stays 1.
// 5) assert res during SEND with 3 chars queued -> next cycle VALIDs=0, level=0,
//    idle=1, overflow=0; no further writes without new pushes.
// 6) push while full with a pop in the same cycle is still rejected (full=1)
//    -> level stays DEPTH-1 after pop, overflow=1.

Source files
------------

// File: rtl/debug_char_writer_if.sv
// Write-side AXI-light bus between a character initiator and the debug console decoder.
// The read channel carries only the initiator's idle outputs.
interface debug_char_writer_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic [31:0] araddr;
  logic        rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/debug_char_writer.sv
// Queues debug characters in a small FIFO and sends each one as a single-beat
// AXI-light write to the debug character address.
module debug_char_writer #(
  parameter logic [31:0] AddrDebug  = 32'h0000_0000,
  parameter int unsigned Depth      = 8,
  parameter int unsigned AsciiWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      res_i,
  input  logic                      push_i,
  input  logic [AsciiWidth-1:0]     push_char_i,
  input  logic                      hold_i,
  output logic                      full_o,
  output logic                      idle_o,
  output logic [$clog2(Depth):0]    level_o,
  output logic                      sent_o,
  output logic                      overflow_o,
  debug_char_writer_if.master       m_axi
);

  localparam int unsigned       PtrW     = $clog2(Depth);
  localparam logic [PtrW:0]     DepthLvl = (PtrW+1)'(Depth);

  typedef enum logic [1:0] {StIdle, StSend, StResp} state_e;

  state_e                state_q, state_d;
  logic [AsciiWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         level_q;
  logic [AsciiWidth-1:0] data_q, data_d;
  logic                  aw_q, aw_d;
  logic                  w_q, w_d;
  logic                  sent_q, sent_d;
  logic                  ovf_q;
  logic                  push_ok;
  logic                  pop;

  // full is judged on the pre-edge level, so a simultaneous pop never frees a slot
  assign push_ok = push_i && !full_o;
  assign pop     = (state_q == StIdle) && (level_q != '0) && !hold_i;

  assign full_o     = (level_q == DepthLvl);
  assign idle_o     = (level_q == '0) && (state_q == StIdle);
  assign level_o    = level_q;
  assign sent_o     = sent_q;
  assign overflow_o = ovf_q;

  assign m_axi.awvalid = aw_q;
  assign m_axi.awaddr  = AddrDebug;
  assign m_axi.wvalid  = w_q;
  assign m_axi.wdata   = {{(32-AsciiWidth){1'b0}}, data_q};
  assign m_axi.wstrb   = 4'b0001;
  assign m_axi.bready  = (state_q == StResp);
  assign m_axi.arvalid = 1'b0;
  assign m_axi.araddr  = '0;
  assign m_axi.rready  = 1'b0;

  always_comb begin
    state_d = state_q;
    aw_d    = aw_q;
    w_d     = w_q;
    data_d  = data_q;
    sent_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StSend;
          aw_d    = 1'b1;
          w_d     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
        end
      end
      StSend: begin
        // address and data handshakes retire independently, in any order
        if (m_axi.awready) aw_d = 1'b0;
        if (m_axi.wready)  w_d  = 1'b0;
        if (!aw_d && !w_d) state_d = StResp;
      end
      StResp: begin
        if (m_axi.bvalid) begin
          state_d = StIdle;
          sent_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q  <= StIdle;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      data_q   <= '0;
      sent_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
      if (push_i && full_o) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_char_i;
  end

endmodule

// File: tb/tb_debug_char_writer.sv
// Bench for debug_char_writer: directed scenarios plus a random phase, with a
// responding bus slave and a queue-based model of accepted and written characters.
module tb_debug_char_writer;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       res;
  logic       push_i;
  logic       hold_i;
  logic [7:0] push_char_i;
  logic       full_o;
  logic       idle_o;
  logic       sent_o;
  logic       overflow_o;
  logic [3:0] level_o;

  always #5 clk = ~clk;

  debug_char_writer_if m_if ();

  debug_char_writer #(
    .AddrDebug (32'h0000_0000),
    .Depth     (Depth),
    .AsciiWidth(8)
  ) dut (
    .clk_i      (clk),
    .res_i      (res),
    .push_i     (push_i),
    .push_char_i(push_char_i),
    .hold_i     (hold_i),
    .full_o     (full_o),
    .idle_o     (idle_o),
    .level_o    (level_o),
    .sent_o     (sent_o),
    .overflow_o (overflow_o),
    .m_axi      (m_if)
  );

  int errors = 0;
  int checks = 0;

  // model and slave state, owned by the negedge process
  logic [7:0] exp_q[$];
  logic [7:0] cur_char;
  int accepted, launched, aw_cnt, w_cnt, b_cnt;
  int aw_wait, w_wait, b_wait;
  int aw_lat, w_lat, b_lat;
  int peak;
  bit rand_lat;
  bit ovf_m, prev_wvalid, aw_hs_prev, w_hs_prev, b_hs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (!(idle_o === 1'b1 && accepted == launched && launched == b_cnt) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  // Slave responder and scoreboard: decides ready/valid for the coming rising edge
  always @(negedge clk) begin
    int  lvl;
    bit  aw_hs, w_hs, b_hs;
    if (res) begin
      m_if.awready = 1'b0;
      m_if.wready  = 1'b0;
      m_if.bvalid  = 1'b0;
      exp_q.delete();
      cur_char = '0;
      accepted = 0; launched = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      ovf_m = 1'b0; prev_wvalid = 1'b0;
      aw_hs_prev = 1'b0; w_hs_prev = 1'b0; b_hs_prev = 1'b0;
    end else begin
      aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
      if (m_if.wvalid === 1'b1 && !prev_wvalid) begin
        launched++;
        chk("launch_has_char", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur_char = exp_q.pop_front();
      end
      prev_wvalid = (m_if.wvalid === 1'b1);
      lvl = accepted - launched;
      if (lvl > peak) peak = lvl;

      chk("level", 32'(level_o), 32'(lvl));
      chk("full", 32'(full_o), 32'(lvl == Depth));
      chk("overflow", 32'(overflow_o), 32'(ovf_m));
      chk("idle", 32'(idle_o), 32'(lvl == 0 && launched == b_cnt));
      chk("sent_pulse", 32'(sent_o), 32'(b_hs_prev));
      chk("bready", 32'(m_if.bready), 32'(aw_cnt > b_cnt && w_cnt > b_cnt));
      chk("read_idle", 32'({m_if.arvalid, m_if.rready}), 32'd0);
      if (aw_hs_prev) chk("awvalid_drop", 32'(m_if.awvalid), 32'd0);
      if (w_hs_prev)  chk("wvalid_drop", 32'(m_if.wvalid), 32'd0);

      if (push_i) begin
        if (lvl < Depth) begin
          accepted++;
          exp_q.push_back(push_char_i);
        end else begin
          ovf_m = 1'b1;
        end
      end

      // response only once both earlier handshakes have retired
      if (aw_cnt > b_cnt && w_cnt > b_cnt) begin
        if (b_wait >= b_lat) begin
          m_if.bvalid = 1'b1;
          if (m_if.bready === 1'b1) begin
            b_hs = 1'b1;
            b_cnt++;
            b_wait = 0;
            if (rand_lat) b_lat = $urandom_range(0, 2);
          end
        end else begin
          m_if.bvalid = 1'b0;
          b_wait++;
        end
      end else begin
        m_if.bvalid = 1'b0;
      end

      if (m_if.awvalid === 1'b1) begin
        if (aw_wait >= aw_lat) begin
          m_if.awready = 1'b1;
          aw_hs = 1'b1;
          aw_cnt++;
          aw_wait = 0;
          chk("awaddr", m_if.awaddr, 32'h0);
          if (rand_lat) aw_lat = $urandom_range(0, 3);
        end else begin
          m_if.awready = 1'b0;
          aw_wait++;
        end
      end else begin
        m_if.awready = 1'b0;
      end

      if (m_if.wvalid === 1'b1) begin
        if (w_wait >= w_lat) begin
          m_if.wready = 1'b1;
          w_hs = 1'b1;
          w_cnt++;
          w_wait = 0;
          chk("wdata", m_if.wdata, {24'h0, cur_char});
          chk("wstrb", 32'(m_if.wstrb), 32'd1);
          if (rand_lat) w_lat = $urandom_range(0, 3);
        end else begin
          m_if.wready = 1'b0;
          w_wait++;
        end
      end else begin
        m_if.wready = 1'b0;
      end

      aw_hs_prev = aw_hs;
      w_hs_prev  = w_hs;
      b_hs_prev  = b_hs;
    end
  end

  initial begin
    int b0;
    logic [7:0] ok_str [3];
    ok_str[0] = 8'h4F; ok_str[1] = 8'h4B; ok_str[2] = 8'h0A;
    res = 1'b1; push_i = 1'b0; hold_i = 1'b0; push_char_i = '0;
    aw_lat = 0; w_lat = 0; b_lat = 0; rand_lat = 1'b0; peak = 0;
    repeat (3) step();
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_flags", 32'({sent_o, overflow_o}), 32'd0);
    chk("rst_valids", 32'({m_if.awvalid, m_if.wvalid, m_if.bready}), 32'd0);
    res = 1'b0;
    step();

    // single 'H', always-ready slave
    push_char_i = 8'h48; push_i = 1'b1;
    step();
    push_i = 1'b0;
    chk("t1_not_yet_valid", 32'(m_if.awvalid), 32'd0);
    chk("t1_level", 32'(level_o), 32'd1);
    step();
    chk("t1_valids", 32'({m_if.awvalid, m_if.wvalid}), 32'h3);
    chk("t1_wdata", m_if.wdata, 32'h48);
    chk("t1_awaddr", m_if.awaddr, 32'h0);
    chk("t1_wstrb", 32'(m_if.wstrb), 32'd1);
    step(); step();
    chk("t1_sent", 32'(sent_o), 32'd1);
    chk("t1_idle", 32'(idle_o), 32'd1);

    // "OK\n" back to back
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      push_char_i = ok_str[i]; push_i = 1'b1;
      step();
    end
    push_i = 1'b0;
    wait_drain(100);
    chk("t2_peak", 32'(peak), 32'd2);

    // AW well ahead of W, then W well ahead of AW
    b0 = b_cnt;
    aw_lat = 0; w_lat = 3;
    push_char_i = 8'h31; push_i = 1'b1;
    step();
    push_i = 1'b0;
    step(); step();
    chk("t3a_split", 32'({m_if.awvalid, m_if.wvalid, m_if.bready}), 32'b010);
    wait_drain(50);
    aw_lat = 3; w_lat = 0;
    push_char_i = 8'h32; push_i = 1'b1;
    step();
    push_i = 1'b0;
    step(); step();
    chk("t3b_split", 32'({m_if.awvalid, m_if.wvalid, m_if.bready}), 32'b100);
    wait_drain(50);
    chk("t3_writes", 32'(b_cnt - b0), 32'd2);
    aw_lat = 0; w_lat = 0;

    // hold, overfill by one, then release
    hold_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_char_i = 8'h61 + 8'(i); push_i = 1'b1;
      step();
    end
    push_i = 1'b0;
    chk("t4_full", 32'(full_o), 32'd1);
    chk("t4_level", 32'(level_o), 32'(Depth));
    chk("t4_overflow", 32'(overflow_o), 32'd1);
    b0 = b_cnt;
    hold_i = 1'b0;
    wait_drain(200);
    chk("t4_writes", 32'(b_cnt - b0), 32'd8);
    chk("t4_overflow_sticky", 32'(overflow_o), 32'd1);

    // reset while a write is stalled in flight with three queued behind it
    aw_lat = 20; w_lat = 20;
    for (int i = 0; i < 4; i++) begin
      push_char_i = 8'h70 + 8'(i); push_i = 1'b1;
      step();
    end
    push_i = 1'b0;
    chk("t5_level_pre", 32'(level_o), 32'd3);
    chk("t5_inflight", 32'(m_if.awvalid), 32'd1);
    res = 1'b1;
    step();
    res = 1'b0;
    chk("t5_valids", 32'({m_if.awvalid, m_if.wvalid}), 32'd0);
    chk("t5_level", 32'(level_o), 32'd0);
    chk("t5_idle", 32'(idle_o), 32'd1);
    chk("t5_overflow", 32'(overflow_o), 32'd0);
    aw_lat = 0; w_lat = 0;
    repeat (10) step();
    chk("t5_no_writes", 32'(launched), 32'd0);

    // push while full coinciding with a pop is still rejected
    hold_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_char_i = 8'h41 + 8'(i); push_i = 1'b1;
      step();
    end
    b0 = b_cnt;
    push_char_i = 8'h5A; push_i = 1'b1; hold_i = 1'b0;
    step();
    push_i = 1'b0;
    chk("t6_level", 32'(level_o), 32'(Depth - 1));
    chk("t6_full", 32'(full_o), 32'd0);
    chk("t6_overflow", 32'(overflow_o), 32'd1);
    wait_drain(200);
    chk("t6_writes", 32'(b_cnt - b0), 32'd8);

    // random traffic, hold and slave latencies
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      push_i      = 1'($urandom_range(0, 1));
      push_char_i = 8'($urandom);
      hold_i      = ($urandom_range(0, 3) == 0);
      step();
    end
    push_i = 1'b0; hold_i = 1'b0;
    wait_drain(600);
    rand_lat = 1'b0;
    aw_lat = 0; w_lat = 0; b_lat = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
